// File: rtl/histo_engine.sv
// Per-frame grey-level histogram engine. It publishes the histogram, the cumulative histogram and a
// percentile threshold into a double-buffered display bank, which is read through a 2-cycle registered port.
module histo_engine #(
    parameter int PIX_W     = 12,
    parameter int BIN_BITS  = 8,
    parameter int CNT_W     = 20,
    parameter int THR_NUM   = 5,
    parameter int THR_SHIFT = 4
) (
    input  logic                iPclk,
    input  logic                iRST_N,
    input  logic                iFval,
    input  logic                iDval,
    input  logic [PIX_W-1:0]    iGrey,
    input  logic [BIN_BITS-1:0] iRd_Addr,
    output logic [CNT_W-1:0]    oHist,
    output logic [CNT_W-1:0]    oCum,
    output logic [BIN_BITS-1:0] oThresh,
    output logic [CNT_W-1:0]    oTotal,
    output logic                oOverflow,
    output logic                oBusy,
    output logic                oFrame_Done,
    output logic                oFrame_Skip
);

    localparam int NBINS = 1 << BIN_BITS;
    localparam int PW    = CNT_W + THR_SHIFT + 1;
    localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
    localparam logic [BIN_BITS-1:0] LAST_BIN = '1;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DUMP, S_CLEAR} state_t;

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W:0] sum);
        return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    endfunction

    state_t              r_state;
    logic [BIN_BITS-1:0] r_idx;
    logic                r_clr_all;
    logic [1:0]          r_drain;
    logic                r_fval_q;
    logic [CNT_W-1:0]    r_total;
    logic                r_ovf;
    logic [CNT_W-1:0]    r_cum;
    logic [BIN_BITS-1:0] r_thr;
    logic                r_thr_found;
    logic                r_bank;
    logic [BIN_BITS-1:0] r_rd_addr_p0;

    logic                r_vld_p0, r_vld_p1, r_vld_p2, r_vld_p3;
    logic [BIN_BITS-1:0] r_bin_p0, r_bin_p1, r_bin_p2, r_bin_p3;
    logic [CNT_W-1:0]    r_rd_p1, r_sum_p2, r_sum_p3;

    logic [CNT_W-1:0] r_acc_mem [NBINS];
    logic [CNT_W-1:0] r_dhist   [2*NBINS];
    logic [CNT_W-1:0] r_dcum    [2*NBINS];

    logic                w_rise, w_busy, w_take, w_thr_hit;
    logic [BIN_BITS-1:0] w_bin;
    logic [CNT_W-1:0]    w_base, w_dump_hist, w_cum_next;
    logic [CNT_W:0]      w_bin_sum, w_tot_sum, w_cum_sum;

    assign w_rise = iFval & ~r_fval_q;
    assign w_busy = (r_state == S_DUMP) || (r_state == S_CLEAR);
    assign oBusy  = w_busy;
    // The pixel on the rising-edge cycle belongs to the frame; nothing is taken once the pipeline drains.
    assign w_take = iFval & iDval & (((r_state == S_ACCUM) && (r_drain == 2'd0)) ||
                                     ((r_state == S_IDLE) && w_rise));
    assign w_bin  = iGrey[PIX_W-1 -: BIN_BITS];

    // The two most recent writes to a bin may not be visible in the registered read yet. Take the newest one.
    assign w_base = (r_vld_p2 && (r_bin_p2 == r_bin_p1)) ? r_sum_p2 :
                    (r_vld_p3 && (r_bin_p3 == r_bin_p1)) ? r_sum_p3 : r_rd_p1;
    assign w_bin_sum   = {1'b0, w_base} + (CNT_W+1)'(1);
    assign w_tot_sum   = {1'b0, r_total} + (CNT_W+1)'(1);
    assign w_dump_hist = r_acc_mem[r_idx];
    assign w_cum_sum   = {1'b0, r_cum} + {1'b0, w_dump_hist};
    assign w_cum_next  = sat_cnt(w_cum_sum);
    assign w_thr_hit   = (PW'(w_cum_next) << THR_SHIFT) >= (PW'(r_total) * PW'(THR_NUM));

    always_ff @(posedge iPclk or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state     <= S_CLEAR;
            r_idx       <= '0;
            r_clr_all   <= 1'b1;
            r_drain     <= '0;
            r_fval_q    <= 1'b0;
            r_total     <= '0;
            r_ovf       <= 1'b0;
            r_cum       <= '0;
            r_thr       <= '0;
            r_thr_found <= 1'b0;
            r_bank      <= 1'b0;
            r_vld_p0    <= 1'b0;
            r_vld_p1    <= 1'b0;
            r_vld_p2    <= 1'b0;
            r_vld_p3    <= 1'b0;
            oThresh     <= '0;
            oTotal      <= '0;
            oOverflow   <= 1'b0;
            oFrame_Done <= 1'b0;
            oFrame_Skip <= 1'b0;
        end else begin
            r_fval_q    <= iFval;
            r_vld_p0    <= w_take;
            r_vld_p1    <= r_vld_p0;
            r_vld_p2    <= r_vld_p1;
            r_vld_p3    <= r_vld_p2;
            oFrame_Done <= 1'b0;
            oFrame_Skip <= w_rise & w_busy;
            if (r_vld_p1 && w_bin_sum[CNT_W])
                r_ovf <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_state <= S_ACCUM;
                        r_drain <= '0;
                        r_ovf   <= 1'b0;
                        r_total <= {{(CNT_W-1){1'b0}}, w_take};
                    end
                end
                S_ACCUM: begin
                    if (w_take) begin
                        r_total <= sat_cnt(w_tot_sum);
                        if (w_tot_sum[CNT_W])
                            r_ovf <= 1'b1;
                    end
                    if ((r_drain != 2'd0) || !iFval) begin
                        if (r_drain == 2'd2) begin
                            r_state     <= S_DUMP;
                            r_drain     <= '0;
                            r_idx       <= '0;
                            r_cum       <= '0;
                            r_thr       <= '0;
                            r_thr_found <= 1'b0;
                        end else begin
                            r_drain <= r_drain + 2'd1;
                        end
                    end
                end
                S_DUMP: begin
                    r_cum <= w_cum_next;
                    if (w_cum_sum[CNT_W])
                        r_ovf <= 1'b1;
                    if (!r_thr_found && w_thr_hit) begin
                        r_thr_found <= 1'b1;
                        r_thr       <= r_idx;
                    end
                    if (r_idx == LAST_BIN) begin
                        r_bank      <= ~r_bank;
                        oThresh     <= r_thr_found ? r_thr : (w_thr_hit ? r_idx : LAST_BIN);
                        oTotal      <= r_total;
                        oOverflow   <= r_ovf | w_cum_sum[CNT_W];
                        oFrame_Done <= 1'b1;
                        r_state     <= S_CLEAR;
                        r_idx       <= '0;
                    end else begin
                        r_idx <= r_idx + BIN_BITS'(1);
                    end
                end
                default: begin
                    if (r_idx == LAST_BIN) begin
                        r_state   <= S_IDLE;
                        r_clr_all <= 1'b0;
                        r_idx     <= '0;
                    end else begin
                        r_idx <= r_idx + BIN_BITS'(1);
                    end
                end
            endcase
        end
    end

    // p0 captures the bin, p1 reads it, p2 holds the incremented count, p3 remembers the last write
    always_ff @(posedge iPclk) begin
        r_bin_p0 <= w_bin;
        r_bin_p1 <= r_bin_p0;
        r_rd_p1  <= r_acc_mem[r_bin_p0];
        r_bin_p2 <= r_bin_p1;
        r_sum_p2 <= sat_cnt(w_bin_sum);
        r_bin_p3 <= r_bin_p2;
        r_sum_p3 <= r_sum_p2;
        if (r_vld_p2)
            r_acc_mem[r_bin_p2] <= r_sum_p2;
        else if (r_state == S_CLEAR)
            r_acc_mem[r_idx] <= '0;
        if (r_state == S_DUMP) begin
            r_dhist[{~r_bank, r_idx}] <= w_dump_hist;
            r_dcum[{~r_bank, r_idx}]  <= w_cum_next;
        end else if ((r_state == S_CLEAR) && r_clr_all) begin
            r_dhist[{1'b0, r_idx}] <= '0;
            r_dhist[{1'b1, r_idx}] <= '0;
            r_dcum[{1'b0, r_idx}]  <= '0;
            r_dcum[{1'b1, r_idx}]  <= '0;
        end
    end

    // Read port: the address is registered first, then data comes from whichever bank is active at that edge.
    always_ff @(posedge iPclk or negedge iRST_N) begin
        if (!iRST_N) begin
            r_rd_addr_p0 <= '0;
            oHist        <= '0;
            oCum         <= '0;
        end else begin
            r_rd_addr_p0 <= iRd_Addr;
            oHist        <= r_dhist[{r_bank, r_rd_addr_p0}];
            oCum         <= r_dcum[{r_bank, r_rd_addr_p0}];
        end
    end

endmodule

// File: tb/tb_histo_engine.sv
// Randomized bench for histo_engine: a 20-bit and a 4-bit counter build share the stimulus and are
// compared with a count-array reference model.
module tb_histo_engine;

    localparam int NBINS = 256;

    logic        iPclk = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iFval = 1'b0;
    logic        iDval = 1'b0;
    logic [11:0] iGrey = '0;
    logic [7:0]  iRd_Addr = '0;

    logic [19:0] hist_a, cum_a, tot_a;
    logic [7:0]  thr_a;
    logic        ovf_a, busy_a, done_a, skip_a;
    logic [3:0]  hist_b, cum_b, tot_b;
    logic [7:0]  thr_b;
    logic        ovf_b, busy_b, done_b, skip_b;

    histo_engine #(.PIX_W(12), .BIN_BITS(8), .CNT_W(20), .THR_NUM(5), .THR_SHIFT(4)) u_dut (
        .iPclk(iPclk), .iRST_N(iRST_N), .iFval(iFval), .iDval(iDval), .iGrey(iGrey),
        .iRd_Addr(iRd_Addr), .oHist(hist_a), .oCum(cum_a), .oThresh(thr_a), .oTotal(tot_a),
        .oOverflow(ovf_a), .oBusy(busy_a), .oFrame_Done(done_a), .oFrame_Skip(skip_a));

    histo_engine #(.PIX_W(12), .BIN_BITS(8), .CNT_W(4), .THR_NUM(5), .THR_SHIFT(4)) u_dut4 (
        .iPclk(iPclk), .iRST_N(iRST_N), .iFval(iFval), .iDval(iDval), .iGrey(iGrey),
        .iRd_Addr(iRd_Addr), .oHist(hist_b), .oCum(cum_b), .oThresh(thr_b), .oTotal(tot_b),
        .oOverflow(ovf_b), .oBusy(busy_b), .oFrame_Done(done_b), .oFrame_Skip(skip_b));

    always #5 iPclk = ~iPclk;

    int n_chk = 0;
    int n_bad = 0;

    int unsigned m_cnt[NBINS];
    int unsigned m_total;
    int unsigned e_hist[2][NBINS];
    int unsigned e_cum[2][NBINS];
    int unsigned e_thr[2], e_tot[2], e_ovf[2];
    int unsigned o_hist[NBINS];
    int unsigned o_cum[NBINS];
    logic [11:0] pix_q[$];

    int   c_done_a, c_done_b, c_skip_a, c_skip_b, c_busy;
    bit   swapped;
    logic [7:0] prev_addr;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned cap(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NBINS; i++) begin
            o_hist[i] = 0;
            o_cum[i]  = 0;
            for (int k = 0; k < 2; k++) begin
                e_hist[k][i] = 0;
                e_cum[k][i]  = 0;
            end
        end
        for (int k = 0; k < 2; k++) begin
            e_thr[k] = 0;
            e_tot[k] = 0;
            e_ovf[k] = 0;
        end
    endtask

    // The display the engine should publish: saturated counts, cumulative sums and the first bin
    // whose cumulative count reaches THR_NUM/2^THR_SHIFT of the total.
    task automatic model_publish();
        for (int i = 0; i < NBINS; i++) begin
            o_hist[i] = e_hist[0][i];
            o_cum[i]  = e_cum[0][i];
        end
        for (int k = 0; k < 2; k++) begin
            int unsigned mx, cum, tot, h;
            bit found, ovf;
            mx    = (k == 0) ? 32'hF_FFFF : 32'hF;
            tot   = cap(m_total, mx);
            ovf   = (m_total > mx);
            cum   = 0;
            found = 0;
            e_thr[k] = NBINS - 1;
            for (int i = 0; i < NBINS; i++) begin
                h = cap(m_cnt[i], mx);
                if (m_cnt[i] > mx) ovf = 1;
                if (cum + h > mx) begin
                    ovf = 1;
                    cum = mx;
                end else begin
                    cum = cum + h;
                end
                e_hist[k][i] = h;
                e_cum[k][i]  = cum;
                if (!found && (longint'(cum) * 16 >= longint'(tot) * 5)) begin
                    found = 1;
                    e_thr[k] = i;
                end
            end
            e_tot[k] = tot;
            e_ovf[k] = ovf;
        end
    endtask

    task automatic reset_seq(input string tg);
        int n;
        repeat (3) @(posedge iPclk);
        #1;
        chk({tg, "_hist"}, hist_a, 0);
        chk({tg, "_cum"}, cum_a, 0);
        chk({tg, "_thr"}, thr_a, 0);
        chk({tg, "_tot"}, tot_a, 0);
        chk({tg, "_ovf"}, ovf_a, 0);
        chk({tg, "_done"}, done_a, 0);
        chk({tg, "_skip"}, skip_a, 0);
        chk({tg, "_busy"}, busy_a, 1);
        @(negedge iPclk);
        iRST_N = 1'b1;
        n = 0;
        while (busy_a && n < 2*NBINS) begin
            @(posedge iPclk);
            #1;
            n++;
        end
        chk({tg, "_busy_len"}, n, NBINS);
        model_clear();
    endtask

    task automatic run_frame(input bit gaps);
        logic [11:0] g;
        for (int i = 0; i < NBINS; i++) m_cnt[i] = 0;
        m_total = 0;
        foreach (pix_q[k]) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                @(negedge iPclk);
                iFval = 1'b1;
                iDval = 1'b0;
                iGrey = 12'($urandom);
            end
            g = pix_q[k];
            @(negedge iPclk);
            iFval = 1'b1;
            iDval = 1'b1;
            iGrey = g;
            m_cnt[g[11:4]]++;
            m_total++;
        end
        if (pix_q.size() == 0)
            repeat (5) begin
                @(negedge iPclk);
                iFval = 1'b1;
                iDval = 1'b0;
            end
        @(negedge iPclk);
        iFval = 1'b0;
        iDval = 1'b0;
        iGrey = 12'($urandom);
        model_publish();
    endtask

    task automatic tick_read(input bit inj);
        logic [7:0] a;
        @(negedge iPclk);
        a = 8'($urandom);
        iRd_Addr = a;
        if (inj) begin
            iFval = 1'b1;
            iDval = 1'($urandom);
            iGrey = 12'($urandom);
        end
        @(posedge iPclk);
        #1;
        chk("swp_hist", hist_a, swapped ? e_hist[0][prev_addr] : o_hist[prev_addr]);
        chk("swp_cum", cum_a, swapped ? e_cum[0][prev_addr] : o_cum[prev_addr]);
        if (done_a) begin
            c_done_a++;
            swapped = 1;
        end
        if (done_b) c_done_b++;
        if (skip_a) c_skip_a++;
        if (skip_b) c_skip_b++;
        if (busy_a) c_busy++;
        prev_addr = a;
    endtask

    task automatic wait_publish(input bit inject);
        int cyc;
        bit inj;
        c_done_a = 0; c_done_b = 0; c_skip_a = 0; c_skip_b = 0; c_busy = 0;
        swapped = 0;
        prev_addr = iRd_Addr;
        cyc = 0;
        inj = 0;
        while (!(c_done_a > 0 && !busy_a) && cyc < 4*NBINS) begin
            if (inject && c_busy >= 2) inj = 1;
            tick_read(inj);
            cyc++;
        end
        chk("publish_in_time", (cyc < 4*NBINS), 1);
        if (inj) begin
            repeat (10) tick_read(1'b1);
            @(negedge iPclk);
            iFval = 1'b0;
            iDval = 1'b0;
            repeat (10) tick_read(1'b0);
        end
        chk("done_pulses", c_done_a, 1);
        chk("done_pulses4", c_done_b, 1);
        chk("skip_pulses", c_skip_a, inject ? 1 : 0);
        chk("skip_pulses4", c_skip_b, inject ? 1 : 0);
        chk("busy_end", busy_a, 0);
    endtask

    task automatic check_published(input string tg);
        chk({tg, "_thr"}, thr_a, e_thr[0]);
        chk({tg, "_tot"}, tot_a, e_tot[0]);
        chk({tg, "_ovf"}, ovf_a, e_ovf[0]);
        chk({tg, "_thr4"}, thr_b, e_thr[1]);
        chk({tg, "_tot4"}, tot_b, e_tot[1]);
        chk({tg, "_ovf4"}, ovf_b, e_ovf[1]);
        for (int i = 0; i <= NBINS; i++) begin
            @(negedge iPclk);
            if (i < NBINS) iRd_Addr = 8'(i);
            @(posedge iPclk);
            #1;
            if (i > 0) begin
                chk($sformatf("%s_hist[%0d]", tg, i-1), hist_a, e_hist[0][i-1]);
                chk($sformatf("%s_cum[%0d]", tg, i-1), cum_a, e_cum[0][i-1]);
                chk($sformatf("%s_hist4[%0d]", tg, i-1), hist_b, e_hist[1][i-1]);
                chk($sformatf("%s_cum4[%0d]", tg, i-1), cum_b, e_cum[1][i-1]);
            end
        end
    endtask

    initial begin
        model_clear();
        reset_seq("por");
        check_published("por");

        pix_q = '{12'h010, 12'h020, 12'h020, 12'hFF0};
        run_frame(1'b0);
        wait_publish(1'b0);
        check_published("fA");

        pix_q.delete();
        repeat (1000) pix_q.push_back(12'h7A0);
        run_frame(1'b0);
        wait_publish(1'b0);
        check_published("fB");

        pix_q.delete();
        repeat (20) pix_q.push_back({8'h03, 4'($urandom)});
        run_frame(1'b0);
        wait_publish(1'b0);
        check_published("fC_sat");

        pix_q.delete();
        repeat (10) pix_q.push_back(12'($urandom));
        run_frame(1'b1);
        wait_publish(1'b1);
        check_published("fD_skip");

        pix_q.delete();
        repeat (400) pix_q.push_back({6'd0, 2'($urandom), 4'($urandom)});
        run_frame(1'b1);
        wait_publish(1'b0);
        check_published("fE_fwd");

        pix_q.delete();
        repeat (300) pix_q.push_back(12'($urandom));
        run_frame(1'b0);
        wait_publish(1'b0);
        check_published("fE_rand");

        pix_q.delete();
        run_frame(1'b0);
        wait_publish(1'b0);
        check_published("fF_empty");

        @(negedge iPclk);
        iFval = 1'b1;
        repeat (30) begin
            @(negedge iPclk);
            iDval = 1'b1;
            iGrey = 12'($urandom);
        end
        iRST_N = 1'b0;
        iFval  = 1'b0;
        iDval  = 1'b0;
        reset_seq("midrst");
        check_published("midrst");

        pix_q.delete();
        repeat (200) pix_q.push_back(12'($urandom));
        run_frame(1'b1);
        wait_publish(1'b0);
        check_published("fG");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
